// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial adder / overflow detector.
package serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WORD_W_MIN = 2;
  localparam int WORD_W_MAX = 32;

  function automatic bit word_w_legal(input int w);
    return (w >= WORD_W_MIN) && (w <= WORD_W_MAX);
  endfunction

  // Unsigned overflow is the MSB carry-out; signed overflow is carry-in xor carry-out of the MSB.
  function automatic logic ovf_sel(input logic signed_mode, input logic cin, input logic cout);
    return signed_mode ? (cin ^ cout) : cout;
  endfunction

endpackage

// File: rtl/serial_adder_ovf_fa.sv
// Combinational full-adder cell used for the single serial bit slice.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder_ovf.sv
// LSB-first bit-serial adder with word framing, stall support and per-word overflow pulse.
module serial_adder_ovf
  import serial_pkg::*;
#(
  parameter int WORD_W      = 4,
  parameter bit SIGNED_MODE = 1'b0,
  parameter bit STICKY_EN   = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid,
  input  logic sof,
  input  logic line1,
  input  logic line2,
  input  logic clr_sticky,
  output logic outp,
  output logic outp_valid,
  output logic word_done,
  output logic overflw,
  output logic ovf_sticky,
  output logic busy
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam bit              WORD_W_OK = word_w_legal(WORD_W);

  generate
    if (!WORD_W_OK) begin : g_bad_word_w
      $error("serial_adder_ovf: WORD_W must be in 2..32");
    end
  endgenerate

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_outp, r_outp_valid, r_word_done, r_overflw, r_sticky;
  logic             w_accept, w_cin, w_sum, w_cout, w_last, w_ovf;

  // sof restarts the word from any state, so it forces bit 0 and a zero carry-in.
  assign w_accept = in_valid & ((r_state == RUN) | sof);
  assign w_cin    = sof ? 1'b0 : r_carry;
  assign w_last   = ~sof & (r_bit_cnt == LAST_BIT);
  assign w_ovf    = ovf_sel(SIGNED_MODE, w_cin, w_cout);

  full_adder_cell u_fa (
    .i_a   (line1),
    .i_b   (line2),
    .i_cin (w_cin),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_carry_nxt   = r_carry;
    if (w_accept) begin
      if (w_last) begin
        w_state_nxt   = IDLE;
        w_bit_cnt_nxt = '0;
        w_carry_nxt   = 1'b0;
      end else begin
        w_state_nxt   = RUN;
        w_bit_cnt_nxt = sof ? CNT_W'(1) : r_bit_cnt + CNT_W'(1);
        w_carry_nxt   = w_cout;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_carry   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_carry   <= w_carry_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_outp       <= 1'b0;
      r_outp_valid <= 1'b0;
      r_word_done  <= 1'b0;
      r_overflw    <= 1'b0;
    end else begin
      if (w_accept) r_outp <= w_sum;
      r_outp_valid <= w_accept;
      r_word_done  <= w_accept & w_last;
      r_overflw    <= w_accept & w_last & w_ovf;
    end
  end

  // The flag follows the registered overflow pulse; a clear in the same cycle wins.
  generate
    if (STICKY_EN) begin : g_sticky
      always_ff @(posedge clock) begin
        if (!reset_n)        r_sticky <= 1'b0;
        else if (clr_sticky) r_sticky <= 1'b0;
        else if (r_overflw)  r_sticky <= 1'b1;
      end
    end else begin : g_no_sticky
      assign r_sticky = 1'b0;
    end
  endgenerate

  assign outp       = r_outp;
  assign outp_valid = r_outp_valid;
  assign word_done  = r_word_done;
  assign overflw    = r_overflw;
  assign ovf_sticky = r_sticky;
  assign busy       = (r_state == RUN);

endmodule

// File: tb/tb_serial_adder_ovf.sv
// Directed bench: unsigned and signed instances share stimulus; expected values are hand-computed.
module tb_serial_adder_ovf;

  logic clock = 1'b0;
  logic reset_n, in_valid, sof, line1, line2, clr_sticky;
  logic u_outp, u_vld, u_wd, u_ovf, u_stk, u_busy;
  logic s_outp, s_vld, s_wd, s_ovf, s_stk, s_busy;
  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  serial_adder_ovf #(.WORD_W(4), .SIGNED_MODE(1'b0), .STICKY_EN(1'b1)) dut_u (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .sof(sof),
    .line1(line1), .line2(line2), .clr_sticky(clr_sticky),
    .outp(u_outp), .outp_valid(u_vld), .word_done(u_wd), .overflw(u_ovf),
    .ovf_sticky(u_stk), .busy(u_busy)
  );

  serial_adder_ovf #(.WORD_W(4), .SIGNED_MODE(1'b1), .STICKY_EN(1'b1)) dut_s (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .sof(sof),
    .line1(line1), .line2(line2), .clr_sticky(clr_sticky),
    .outp(s_outp), .outp_valid(s_vld), .word_done(s_wd), .overflw(s_ovf),
    .ovf_sticky(s_stk), .busy(s_busy)
  );

  // Apply one cycle of inputs and return 1 time unit after the capturing edge.
  task automatic cyc(input logic v, input logic sf, input logic a, input logic b);
    in_valid = v; sof = sf; line1 = a; line2 = b;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clr_sticky = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 1);
    n_vec++;
    if ({u_outp, u_vld, u_wd, u_ovf, u_stk, u_busy} !== 6'b0) begin
      n_err++; $display("FAIL reset_u outs=%b exp 000000", {u_outp, u_vld, u_wd, u_ovf, u_stk, u_busy});
    end
    n_vec++;
    if ({s_outp, s_vld, s_wd, s_ovf, s_stk, s_busy} !== 6'b0) begin
      n_err++; $display("FAIL reset_s outs=%b exp 000000", {s_outp, s_vld, s_wd, s_ovf, s_stk, s_busy});
    end
    reset_n = 1'b1;
    cyc(1, 0, 1, 1);
    n_vec++;
    if (u_vld !== 1'b0 || u_busy !== 1'b0) begin
      n_err++; $display("FAIL idle_ignore valid=%b busy=%b exp 0/0", u_vld, u_busy);
    end
  endtask

  task automatic test_unsigned;
    logic [3:0] a, b, e;
    a = 4'd3; b = 4'd5; e = 4'd8;
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 0, a[i], b[i]);
      n_vec++;
      if (u_outp !== e[i] || u_vld !== 1'b1 || u_wd !== (i == 3)) begin
        n_err++; $display("FAIL u3p5 bit%0d outp/vld/wd=%b%b%b exp %b1%b", i, u_outp, u_vld, u_wd, e[i], i == 3);
      end
    end
    n_vec++;
    if (u_ovf !== 1'b0) begin n_err++; $display("FAIL u3p5_ovf got %b exp 0", u_ovf); end
    a = 4'd9; b = 4'd8; e = 4'd1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 0, a[i], b[i]);
      n_vec++;
      if (u_outp !== e[i] || u_wd !== (i == 3) || u_ovf !== (i == 3)) begin
        n_err++; $display("FAIL u9p8 bit%0d outp/wd/ovf=%b%b%b exp %b%b%b", i, u_outp, u_wd, u_ovf, e[i], i == 3, i == 3);
      end
    end
    cyc(0, 0, 0, 0);
    n_vec++;
    if (u_stk !== 1'b1 || u_ovf !== 1'b0) begin
      n_err++; $display("FAIL u9p8_sticky stk/ovf=%b%b exp 10", u_stk, u_ovf);
    end
  endtask

  task automatic test_signed;
    logic [3:0] a, b, e;
    a = 4'd5; b = 4'd4; e = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 0, a[i], b[i]);
      n_vec++;
      if (s_outp !== e[i] || s_wd !== (i == 3)) begin
        n_err++; $display("FAIL s5p4 bit%0d outp/wd=%b%b exp %b%b", i, s_outp, s_wd, e[i], i == 3);
      end
    end
    n_vec++;
    if (s_ovf !== 1'b1 || u_ovf !== 1'b0) begin
      n_err++; $display("FAIL s5p4_ovf s/u=%b%b exp 10", s_ovf, u_ovf);
    end
    a = 4'hF; b = 4'hF; e = 4'hE;
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 0, a[i], b[i]);
      n_vec++;
      if (s_outp !== e[i] || s_wd !== (i == 3)) begin
        n_err++; $display("FAIL sm1 bit%0d outp/wd=%b%b exp %b%b", i, s_outp, s_wd, e[i], i == 3);
      end
    end
    n_vec++;
    if (s_ovf !== 1'b0 || u_ovf !== 1'b1) begin
      n_err++; $display("FAIL sm1_ovf s/u=%b%b exp 01", s_ovf, u_ovf);
    end
  endtask

  task automatic test_stall;
    logic [5:0] v, e, wd;
    logic [3:0] a, b;
    int k;
    a = 4'd3; b = 4'd5;
    v = 6'b110011; e = 6'b100000; wd = 6'b100000;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (v[c]) begin cyc(1, k == 0, a[k], b[k]); k++; end
      else cyc(0, 0, 1, 1);
      n_vec++;
      if (u_vld !== v[c] || u_outp !== e[c] || u_wd !== wd[c] || u_busy !== (c < 5)) begin
        n_err++; $display("FAIL stall cyc%0d vld/outp/wd/busy=%b%b%b%b exp %b%b%b%b",
                          c, u_vld, u_outp, u_wd, u_busy, v[c], e[c], wd[c], c < 5);
      end
    end
  endtask

  task automatic test_sof_abort;
    logic [3:0] a, b, e;
    a = 4'd3; b = 4'd5; e = 4'd8;
    cyc(1, 1, 1, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 0, a[i], b[i]);
      n_vec++;
      if (u_outp !== e[i] || u_wd !== (i == 3) || u_ovf !== 1'b0) begin
        n_err++; $display("FAIL abort bit%0d outp/wd/ovf=%b%b%b exp %b%b0", i, u_outp, u_wd, u_ovf, e[i], i == 3);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b, e;
    a = {4'd9, 4'd3}; b = {4'd8, 4'd5}; e = {4'd1, 4'd8};
    for (int i = 0; i < 8; i++) begin
      cyc(1, (i % 4) == 0, a[i], b[i]);
      n_vec++;
      if (u_outp !== e[i] || u_vld !== 1'b1 || u_wd !== ((i % 4) == 3) || u_ovf !== (i == 7)) begin
        n_err++; $display("FAIL b2b bit%0d outp/vld/wd/ovf=%b%b%b%b exp %b1%b%b",
                          i, u_outp, u_vld, u_wd, u_ovf, e[i], (i % 4) == 3, i == 7);
      end
    end
  endtask

  task automatic test_reset_mid;
    cyc(1, 1, 1, 1);
    cyc(1, 0, 1, 0);
    reset_n = 1'b0;
    cyc(1, 0, 1, 1);
    n_vec++;
    if ({u_outp, u_vld, u_wd, u_ovf, u_stk, u_busy} !== 6'b0) begin
      n_err++; $display("FAIL reset_mid outs=%b exp 000000", {u_outp, u_vld, u_wd, u_ovf, u_stk, u_busy});
    end
    reset_n = 1'b1;
    cyc(1, 0, 1, 1);
    n_vec++;
    if (u_vld !== 1'b0 || u_wd !== 1'b0 || u_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_idle vld/wd/busy=%b%b%b exp 000", u_vld, u_wd, u_busy);
    end
  endtask

  task automatic test_sticky_clr;
    logic [3:0] a, b;
    a = 4'd9; b = 4'd8;
    for (int i = 0; i < 4; i++) cyc(1, i == 0, a[i], b[i]);
    n_vec++;
    if (u_ovf !== 1'b1) begin n_err++; $display("FAIL clr_pulse ovf=%b exp 1", u_ovf); end
    clr_sticky = 1'b1;
    cyc(0, 0, 0, 0);
    clr_sticky = 1'b0;
    n_vec++;
    if (u_stk !== 1'b0) begin n_err++; $display("FAIL clr_prio stk=%b exp 0", u_stk); end
    cyc(0, 0, 0, 0);
    n_vec++;
    if (u_stk !== 1'b0) begin n_err++; $display("FAIL clr_hold stk=%b exp 0", u_stk); end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; sof = 1'b0; line1 = 1'b0; line2 = 1'b0; clr_sticky = 1'b0;
    test_reset;
    test_unsigned;
    test_signed;
    test_stall;
    test_sof_abort;
    test_back_to_back;
    test_reset_mid;
    test_sticky_clr;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ovf.md
Name: serial_adder_ovf

Overview:
Parametrised bit-serial adder/overflow detector for two serial operand streams, line1 and line2, both LSB-first.
- Successor to the fixed 3-bit serial-comparison FSM; adds configurable word length, a signed/unsigned overflow mode, valid-qualified stalling and explicit word framing.
- Sits between serial line receivers and the downstream status/checker logic.
- Emits one registered sum bit per accepted input bit, plus an overflow pulse on the last bit of each word.

Parameters:
WORD_W, 4, bits per operand word; legal range 2..32.
SIGNED_MODE, 0, 0 = unsigned overflow (carry out of MSB); 1 = two's-complement overflow (carry into MSB xor carry out of MSB).
STICKY_EN, 1, 1 = implement the sticky overflow flag ovf_sticky; 0 = ovf_sticky tied to 0.

Ports:
clock  in  1  single system clock, rising edge.
reset_n  in  1  synchronous, active-low reset.
in_valid  in  1  line1/line2/sof are qualified this cycle.
sof  in  1  start of word; marks the LSB bit, valid only with in_valid.
line1  in  1  operand A serial bit.
line2  in  1  operand B serial bit.
clr_sticky  in  1  clears ovf_sticky.
outp  out  1  sum bit, registered.
outp_valid  out  1  outp is valid this cycle.
word_done  out  1  pulses with the MSB sum bit.
overflw  out  1  overflow result; valid only when word_done=1, else 0.
ovf_sticky  out  1  set by any overflow pulse, held until cleared.
busy  out  1  a word is in progress (state RUN).

Behaviour:
Reset (reset_n=0 at a clock edge):
- Outputs outp, outp_valid, word_done, overflw, ovf_sticky, busy all 0.
- State IDLE, carry=0, bit_cnt=0.
- Reset mid-word discards the partial word; no word_done is emitted for it.

States (binary encoded):
- IDLE: waits for in_valid & sof; line1/line2 without sof are ignored (no output).
- RUN: accumulating bits 1..WORD_W-1.

Per accepted bit (in_valid=1 and either state=RUN or sof=1):
- s = line1 ^ line2 ^ cin, where cin = 0 on the sof bit, else the carry register.
- cout = majority(line1, line2, cin); the carry register takes cout.
- outp <= s; outp_valid <= 1 at the next edge. Latency: exactly 1 cycle from input to outp.
- bit_cnt increments; at bit_cnt == WORD_W-1 (the MSB):
  - word_done <= 1 and overflw <= (SIGNED_MODE ? cin ^ cout : cout).
  - State returns to IDLE, bit_cnt to 0, carry to 0.

Stall: in_valid=0 in RUN holds state, carry and bit_cnt; outp_valid, word_done and overflw are 0 that cycle; outp holds its last value.

sof rules:
- sof while in RUN aborts the current word without word_done and restarts at bit 0 with cin=0. The accepted sof bit produces its outp normally.
- sof together with the MSB of a word cannot occur, because the MSB position is counted. sof on the cycle after the MSB starts the next word back-to-back with no bubble.

ovf_sticky:
- Set on the cycle overflw=1.
- clr_sticky has priority over a simultaneous set, so the result is 0 that cycle.

Width rules:
- bit_cnt width = $clog2(WORD_W).
- No internal word storage; operands are never buffered.

Decomposition:
- Shared package serial_pkg: state enum (IDLE, RUN), a function for the overflow select, and a WORD_W legality check constant.
- One natural sub-module, full_adder_cell (sum/carry combinational).
- The FSM, counter and sticky flag stay in the top.

Test Plan:
- Unsigned, WORD_W=4. A=3 (1,1,0,0), B=5 (1,0,1,0), sof on bit 0. Required: outp = 0,0,0,1 (8); word_done on the 4th output; overflw=0.
- Unsigned. A=9, B=8. Required: outp = 1,0,0,0 (1); overflw=1; ovf_sticky=1 afterwards.
- SIGNED_MODE=1. A=5, B=4. Required: outp = 1,0,0,1; overflw=1.
- SIGNED_MODE=1. A=-1, B=-1. Required: outp = 0,1,1,1 (-2); overflw=0, even though the MSB carry-out is 1.
- Stall and restart:
  - 3+5 with in_valid=0 for 2 cycles after bit 1 → same sum bits, word_done delayed by 2 cycles.
  - sof asserted at bit 2 → no word_done for the aborted word; the new word sums correctly.
- Reset and sticky clear:
  - reset_n=0 at bit 2 → all outputs 0 next cycle, state IDLE.
  - clr_sticky together with an overflow pulse → ovf_sticky=0.
